conv_out_buf_writer: RTL

//  Downstream of the conv FIFO drain stage. Takes each valid output row word with its y/x/f indices,

---
 rtl/conv_out_buf_writer_pkg.sv | 46 ++++
 rtl/conv_out_wr_fifo.sv | 52 +++++
 rtl/conv_out_buf_writer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/conv_out_buf_writer_pkg.sv
// Shared constants, FSM encoding and address helper for the conv output-buffer writer.
// Build option: CONV_OUT_WR_RELU_EN (consumed by conv_out_buf_writer).
package conv_out_buf_writer_pkg;

  localparam int PE_PARALLEL_PIXEL_88  = 2;
  localparam int PE_PARALLEL_WEIGHT_88 = 4;
  localparam int COLUMN_NUM            = 4;

  localparam int DEF_QUANTIFIED_PIXEL_WIDTH = 8;
  localparam int DEF_CONV_OUT_DATA_WIDTH    = DEF_QUANTIFIED_PIXEL_WIDTH * PE_PARALLEL_PIXEL_88
                                              * PE_PARALLEL_WEIGHT_88 * COLUMN_NUM;
  localparam int DEF_PIXELS_IN_ROW_IN_2POW  = 5;
  localparam int DEF_FIFO_DEPTH_IN_2POW     = 3;

  localparam int ADR_WIDTH = 16;
  localparam int IDX_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wr_state_e;

  // Row-major word address; evaluated in 32 bits and truncated so it wraps modulo 2^16.
  function automatic logic [ADR_WIDTH-1:0] word_adr(
    input logic [IDX_WIDTH-1:0] y,
    input logic [IDX_WIDTH-1:0] x,
    input logic [IDX_WIDTH-1:0] f,
    input logic [3:0]           of_l2,
    input logic [3:0]           ox_l2,
    input int unsigned          pix_l2
  );
    logic [31:0] y_term;
    logic [31:0] x_term;
    logic [31:0] sum;
    int          shift;
    shift = int'(of_l2) + int'(ox_l2) - int'(pix_l2);
    if (shift >= 0) y_term = {16'b0, y} << shift;
    else            y_term = {16'b0, y} >> (-shift);
    x_term = ({16'b0, x} << of_l2) >> pix_l2;
    sum    = y_term + x_term + {16'b0, f};
    return sum[ADR_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/conv_out_wr_fifo.sv
// First-word-fall-through write queue: the head entry is visible on rdata whenever empty is low.
// A push while full is taken only when a pop happens in the same cycle.
module conv_out_wr_fifo #(
  parameter int WIDTH         = 8,
  parameter int DEPTH_IN_2POW = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             single
);

  localparam int DEPTH = 1 << DEPTH_IN_2POW;
  localparam int PW    = DEPTH_IN_2POW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == PW'(DEPTH));
  assign single  = (count == PW'(1));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[DEPTH_IN_2POW-1:0]];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[DEPTH_IN_2POW-1:0]] <= wdata;
  end

endmodule

// File: rtl/conv_out_buf_writer.sv
// Computes output-buffer word addresses, queues words and writes them under a ready handshake.
// Build option: CONV_OUT_WR_RELU_EN clamps each signed pixel lane to zero when negative.
module conv_out_buf_writer
  import conv_out_buf_writer_pkg::*;
#(
  parameter int PIXELS_IN_ROW_IN_2POW  = DEF_PIXELS_IN_ROW_IN_2POW,
  parameter int CONV_OUT_DATA_WIDTH    = DEF_CONV_OUT_DATA_WIDTH,
  parameter int QUANTIFIED_PIXEL_WIDTH = DEF_QUANTIFIED_PIXEL_WIDTH,
  parameter int FIFO_DEPTH_IN_2POW     = DEF_FIFO_DEPTH_IN_2POW
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [3:0]                     of_in_2pow,
  input  logic [3:0]                     ox_in_2pow,
  input  logic                           valid_rowi_out_buf_adr,
  input  logic [IDX_WIDTH-1:0]           out_y_idx,
  input  logic [IDX_WIDTH-1:0]           out_x_idx,
  input  logic [IDX_WIDTH-1:0]           out_f_idx,
  input  logic [CONV_OUT_DATA_WIDTH-1:0] conv_out_data,
  input  logic                           conv_fifo_out_tile_add_end,
  output logic                           out_buf_wr_en,
  output logic [ADR_WIDTH-1:0]           out_buf_wr_adr,
  output logic [CONV_OUT_DATA_WIDTH-1:0] out_buf_wr_data,
  input  logic                           out_buf_wr_ready,
  output logic                           tile_wr_done,
  output logic                           busy,
  output logic                           overflow
);

  localparam int W       = CONV_OUT_DATA_WIDTH;
  localparam int QW      = QUANTIFIED_PIXEL_WIDTH;
  localparam int LANES   = W / QW;
  localparam int ENTRY_W = 1 + ADR_WIDTH + W;

  // ---------------- stage 1: address and optional clamp ----------------
  logic [W-1:0]         s0_data;
  logic [ADR_WIDTH-1:0] s0_adr;
  logic                 s1_valid;
  logic                 s1_last;
  logic [ADR_WIDTH-1:0] s1_adr;
  logic [W-1:0]         s1_data;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
`ifdef CONV_OUT_WR_RELU_EN
    assign s0_data[i*QW +: QW] = conv_out_data[i*QW + QW - 1] ? '0 : conv_out_data[i*QW +: QW];
`else
    assign s0_data[i*QW +: QW] = conv_out_data[i*QW +: QW];
`endif
  end

  assign s0_adr = word_adr(out_y_idx, out_x_idx, out_f_idx, of_in_2pow, ox_in_2pow,
                           PIXELS_IN_ROW_IN_2POW);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_adr   <= '0;
      s1_data  <= '0;
    end else begin
      s1_valid <= valid_rowi_out_buf_adr;
      s1_last  <= valid_rowi_out_buf_adr && conv_fifo_out_tile_add_end;
      if (valid_rowi_out_buf_adr) begin
        s1_adr  <= s0_adr;
        s1_data <= s0_data;
      end
    end
  end

  // ---------------- stage 2: write queue ----------------
  logic [ENTRY_W-1:0]   head;
  logic                 head_last;
  logic [ADR_WIDTH-1:0] head_adr;
  logic [W-1:0]         head_data;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_single;
  logic                 wr_pop;
  logic                 drop;

  conv_out_wr_fifo #(
    .WIDTH         (ENTRY_W),
    .DEPTH_IN_2POW (FIFO_DEPTH_IN_2POW)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (s1_valid),
    .wdata  ({s1_last, s1_adr, s1_data}),
    .pop    (wr_pop),
    .rdata  (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .single (fifo_single)
  );

  assign {head_last, head_adr, head_data} = head;

  // Head is gated so the write port reads all-zero whenever nothing is queued.
  assign out_buf_wr_en   = !fifo_empty;
  assign out_buf_wr_adr  = fifo_empty ? '0 : head_adr;
  assign out_buf_wr_data = fifo_empty ? '0 : head_data;
  assign wr_pop          = out_buf_wr_en && out_buf_wr_ready;
  assign drop            = s1_valid && fifo_full && !wr_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end

  // ---------------- tile FSM ----------------
  wr_state_e state_q;
  wr_state_e state_d;
  logic      last_pend_q;
  logic      tail_seen;
  logic      drained;

  // A last word counts whether it was queued or dropped.
  assign tail_seen = s1_valid && s1_last;
  // Leaving DRAIN as the final queued word is written lets done follow the last write directly.
  assign drained   = !s1_valid && (fifo_empty || (fifo_single && wr_pop && head_last));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      last_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      // A tile end seen while entering RUN is remembered so RUN still hands over to DRAIN.
      last_pend_q <= tail_seen && (state_q == ST_IDLE || state_q == ST_DONE);
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (s1_valid) state_d = ST_RUN;
      ST_RUN:   if (tail_seen || last_pend_q) state_d = ST_DRAIN;
      ST_DRAIN: if (drained) state_d = ST_DONE;
      ST_DONE:  state_d = s1_valid ? ST_RUN : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tile_wr_done = (state_q == ST_DONE);
    busy         = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  end

endmodule
